fb_pingpong_ctrl: RTL and testbench

FB_PINGPONG_CTRL -- requirements
Module: fb_pingpong_ctrl

---
 rtl/fb_pingpong_ctrl_pkg.sv | 14 +
 rtl/fb_pingpong_ctrl_sat_counter.sv | 34 +++
 rtl/fb_pingpong_ctrl.sv | 128 ++++++++++++
 tb/tb_fb_pingpong_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pingpong_ctrl_pkg.sv
// Shared constants and FSM encoding for the ping-pong frame buffer controller.
package fb_pingpong_ctrl_pkg;

  localparam int c_img_pxls    = 4800;
  localparam int c_nb_img_pxls = 13;
  localparam int c_nb_drop     = 8;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_FILL     = 2'd1,
    ST_HOLD     = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/fb_pingpong_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [width-1:0] q
);

  logic [width-1:0] cnt_q;
  logic [width-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame buffer arbiter: capture fills one bank while display reads the
// other; banks swap only when a full frame is held and the display finishes a pass.
module fb_pingpong_ctrl #(
  parameter int c_img_pxls    = fb_pingpong_ctrl_pkg::c_img_pxls,
  parameter int c_nb_img_pxls = fb_pingpong_ctrl_pkg::c_nb_img_pxls,
  parameter int c_nb_drop     = fb_pingpong_ctrl_pkg::c_nb_drop
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     cap_we,
  input  logic [c_nb_img_pxls-1:0] cap_addr,
  input  logic                     disp_frame_end,
  input  logic                     freeze,
  output logic [1:0]               bank_we,
  output logic                     wr_bank,
  output logic                     rd_bank,
  output logic                     frame_valid,
  output logic                     swap,
  output logic [c_nb_drop-1:0]     drop_cnt,
  output logic                     short_frame,
  output logic [1:0]               state
);

  import fb_pingpong_ctrl_pkg::*;

  localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_pxls - 1);

  fsm_state_e state_q;
  fsm_state_e state_d;
  logic       wr_bank_q;
  logic       wr_bank_d;
  logic       frame_valid_q;
  logic       frame_valid_d;
  logic       swap_q;
  logic       swap_d;
  logic       short_frame_q;
  logic       short_frame_d;
  logic       drop_inc;
  logic       last_wr;

  assign last_wr = cap_we && (cap_addr == c_last_addr);

  // A restart in FILL wins over a coincident last write: the frame begins again.
  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    frame_valid_d = frame_valid_q;
    swap_d        = 1'b0;
    short_frame_d = 1'b0;
    drop_inc      = 1'b0;
    case (state_q)
      ST_WAIT_SOF: begin
        if (frame_start && !freeze) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (frame_start) begin
          short_frame_d = 1'b1;
        end else if (last_wr) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (disp_frame_end) begin
          swap_d        = 1'b1;
          frame_valid_d = 1'b1;
          wr_bank_d     = ~wr_bank_q;
          state_d       = (frame_start && !freeze) ? ST_FILL : ST_WAIT_SOF;
        end else if (frame_start) begin
          drop_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT_SOF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_SOF;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      swap_q        <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      frame_valid_q <= frame_valid_d;
      swap_q        <= swap_d;
      short_frame_q <= short_frame_d;
    end
  end

  sat_counter #(
    .width (c_nb_drop)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .clear (1'b0),
    .q     (drop_cnt)
  );

  // Only the capture-owned bank may ever see a write strobe.
  always_comb begin
    bank_we = 2'b00;
    if (state_q == ST_FILL) begin
      bank_we = {wr_bank_q & cap_we, ~wr_bank_q & cap_we};
    end
  end

  assign wr_bank     = wr_bank_q;
  assign rd_bank     = ~wr_bank_q;
  assign frame_valid = frame_valid_q;
  assign swap        = swap_q;
  assign short_frame = short_frame_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Directed self-checking bench for fb_pingpong_ctrl; a second instance with a
// 2-bit drop counter exercises saturation.
module tb_fb_pingpong_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        cap_we;
  logic [12:0] cap_addr;
  logic        disp_frame_end;
  logic        freeze;

  logic [1:0]  bank_we;
  logic        wr_bank;
  logic        rd_bank;
  logic        frame_valid;
  logic        swap;
  logic [7:0]  drop_cnt;
  logic        short_frame;
  logic [1:0]  state;

  logic [1:0]  bank_we_s;
  logic        wr_bank_s;
  logic        rd_bank_s;
  logic        frame_valid_s;
  logic        swap_s;
  logic [1:0]  drop_cnt_s;
  logic        short_frame_s;
  logic [1:0]  state_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fb_pingpong_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .cap_we(cap_we),
    .cap_addr(cap_addr), .disp_frame_end(disp_frame_end), .freeze(freeze),
    .bank_we(bank_we), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .frame_valid(frame_valid), .swap(swap), .drop_cnt(drop_cnt),
    .short_frame(short_frame), .state(state)
  );

  fb_pingpong_ctrl #(.c_nb_drop(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .cap_we(cap_we),
    .cap_addr(cap_addr), .disp_frame_end(disp_frame_end), .freeze(freeze),
    .bank_we(bank_we_s), .wr_bank(wr_bank_s), .rd_bank(rd_bank_s),
    .frame_valid(frame_valid_s), .swap(swap_s), .drop_cnt(drop_cnt_s),
    .short_frame(short_frame_s), .state(state_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; frame_start = 1'b0; cap_we = 1'b1; cap_addr = '0;
    disp_frame_end = 1'b0; freeze = 1'b0;
    tick(); tick();
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
    checks++; if (wr_bank !== 1'b0 || rd_bank !== 1'b1) begin errors++; $display("[TB] FAIL reset_banks: wr=%b rd=%b want wr=0 rd=1", wr_bank, rd_bank); end
    checks++; if (frame_valid !== 1'b0 || swap !== 1'b0 || short_frame !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: fv=%b swap=%b short=%b want 000", frame_valid, swap, short_frame); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d want 0", drop_cnt); end
    checks++; if (bank_we !== 2'b00) begin errors++; $display("[TB] FAIL reset_bank_we: got %b want 00", bank_we); end
    cap_we = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  // Starts a frame from WAIT_SOF and writes all 4800 pixels.
  task automatic fill_frame(input logic [1:0] exp_we, input bit dfe_mid, input bit dfe_last);
    int bad;
    frame_start = 1'b1; cap_we = 1'b1; cap_addr = '0;
    #1;
    checks++; if (bank_we !== 2'b00) begin errors++; $display("[TB] FAIL sof_cycle_block: got %b want 00", bank_we); end
    tick();
    frame_start = 1'b0;
    bad = 0;
    for (int a = 0; a < 4800; a++) begin
      cap_we = 1'b1;
      cap_addr = 13'(a);
      disp_frame_end = (dfe_mid && a == 50) || (dfe_last && a == 4799);
      #1;
      if (state !== 2'd1 || bank_we !== exp_we || swap !== 1'b0) bad++;
      tick();
    end
    cap_we = 1'b0; disp_frame_end = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL fill_writes: %0d bad cycles want 0 (bank_we exp %b)", bad, exp_we); end
    checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL fill_to_hold: got %0d want 2", state); end
    cap_we = 1'b1; cap_addr = 13'd4799;
    #1;
    checks++; if (bank_we !== 2'b00) begin errors++; $display("[TB] FAIL hold_no_write: got %b want 00", bank_we); end
    cap_we = 1'b0;
  endtask

  task automatic test_fill;
    fill_frame(2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_swap;
    disp_frame_end = 1'b1;
    tick();
    disp_frame_end = 1'b0;
    checks++; if (swap !== 1'b1) begin errors++; $display("[TB] FAIL swap_pulse: got %b want 1", swap); end
    checks++; if (wr_bank !== 1'b1 || rd_bank !== 1'b0) begin errors++; $display("[TB] FAIL swap_banks: wr=%b rd=%b want wr=1 rd=0", wr_bank, rd_bank); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL swap_valid: got %b want 1", frame_valid); end
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL swap_state: got %0d want 0", state); end
    tick();
    checks++; if (swap !== 1'b0) begin errors++; $display("[TB] FAIL swap_one_cycle: got %b want 0", swap); end
  endtask

  task automatic test_drop;
    fill_frame(2'b10, 1'b0, 1'b0);
    repeat (3) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    end
    checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL drop_stay_hold: got %0d want 2", state); end
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("[TB] FAIL drop_cnt3: got %0d want 3", drop_cnt); end
    checks++; if (drop_cnt_s !== 2'd3) begin errors++; $display("[TB] FAIL drop_small3: got %0d want 3", drop_cnt_s); end
    repeat (2) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    end
    checks++; if (drop_cnt !== 8'd5) begin errors++; $display("[TB] FAIL drop_cnt5: got %0d want 5", drop_cnt); end
    checks++; if (drop_cnt_s !== 2'd3) begin errors++; $display("[TB] FAIL drop_saturate: got %0d want 3", drop_cnt_s); end
    disp_frame_end = 1'b1; tick(); disp_frame_end = 1'b0;
    checks++; if (swap !== 1'b1 || wr_bank !== 1'b0 || state !== 2'd0) begin errors++; $display("[TB] FAIL drop_swap: swap=%b wr=%b st=%0d want 1 0 0", swap, wr_bank, state); end
    checks++; if (drop_cnt !== 8'd5) begin errors++; $display("[TB] FAIL drop_hold_after_swap: got %0d want 5", drop_cnt); end
  endtask

  task automatic test_back_to_back;
    fill_frame(2'b01, 1'b0, 1'b0);
    frame_start = 1'b1; disp_frame_end = 1'b1;
    tick();
    frame_start = 1'b0; disp_frame_end = 1'b0;
    checks++; if (swap !== 1'b1) begin errors++; $display("[TB] FAIL b2b_swap: got %b want 1", swap); end
    checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL b2b_state: got %0d want 1", state); end
    checks++; if (drop_cnt !== 8'd5) begin errors++; $display("[TB] FAIL b2b_no_drop: got %0d want 5", drop_cnt); end
    cap_we = 1'b1; cap_addr = 13'd0;
    #1;
    checks++; if (bank_we !== 2'b10) begin errors++; $display("[TB] FAIL b2b_bank_we: got %b want 10", bank_we); end
    tick();
    cap_addr = 13'd5000;
    #1;
    checks++; if (bank_we !== 2'b10) begin errors++; $display("[TB] FAIL oob_write: got %b want 10", bank_we); end
    tick();
    cap_we = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL oob_no_end: got %0d want 1", state); end
  endtask

  task automatic test_short_frame;
    for (int a = 0; a < 100; a++) begin
      cap_we = 1'b1; cap_addr = 13'(a); tick();
    end
    cap_we = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (short_frame !== 1'b1) begin errors++; $display("[TB] FAIL short_pulse: got %b want 1", short_frame); end
    checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL short_state: got %0d want 1", state); end
    tick();
    checks++; if (short_frame !== 1'b0) begin errors++; $display("[TB] FAIL short_one_cycle: got %b want 0", short_frame); end
  endtask

  task automatic test_reset_mid_fill;
    int bad;
    for (int a = 0; a < 2000; a++) begin
      cap_we = 1'b1; cap_addr = 13'(a); tick();
    end
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || wr_bank !== 1'b0 || rd_bank !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_state: st=%0d wr=%b rd=%b want 0 0 1", state, wr_bank, rd_bank); end
    checks++; if (frame_valid !== 1'b0 || swap !== 1'b0 || short_frame !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rst_mid_flags: fv=%b swap=%b short=%b drop=%0d want 0 0 0 0", frame_valid, swap, short_frame, drop_cnt); end
    checks++; if (bank_we !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_bank_we: got %b want 00", bank_we); end
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int a = 0; a < 5; a++) begin
      cap_we = 1'b1; cap_addr = 13'(a);
      #1;
      if (bank_we !== 2'b00 || state !== 2'd0) bad++;
      tick();
    end
    cap_we = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL post_rst_no_write: %0d bad cycles want 0", bad); end
  endtask

  task automatic test_freeze_and_overlap;
    freeze = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (state !== 2'd0 || drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL freeze_stay: st=%0d drop=%0d want 0 0", state, drop_cnt); end
    freeze = 1'b0;
    fill_frame(2'b01, 1'b1, 1'b1);
    tick();
    checks++; if (swap !== 1'b0 || wr_bank !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL last_dfe_no_swap: swap=%b wr=%b fv=%b want 0 0 0", swap, wr_bank, frame_valid); end
    disp_frame_end = 1'b1; tick(); disp_frame_end = 1'b0;
    checks++; if (swap !== 1'b1 || wr_bank !== 1'b1 || frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL late_swap: swap=%b wr=%b fv=%b want 1 1 1", swap, wr_bank, frame_valid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_swap();
    test_drop();
    test_back_to_back();
    test_short_frame();
    test_reset_mid_fill();
    test_freeze_and_overlap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
